pipelined_ripple_adder: RTL and testbench
=========================================

# pipelined_ripple_adder

Parametrised, pipelined ripple-carry adder/subtractor. A WIDTH-bit operation is split into SEG_WIDTH-bit ripple segments, one per pipeline stage, with the inter-segment carry registered between stages. The block accepts one operation per cycle under a valid/ready handshake and stalls cleanly on downstream backpressure. It serves as the datapath arithmetic unit wherever a wide add is too slow to ripple in one cycle.

## Interface
- WIDTH, 32: operand and result width in bits; must be a multiple of SEG_WIDTH.
- SEG_WIDTH, 8: bits per ripple segment, which is also bits per pipeline stage.
- Derived, not overridable: STAGES = WIDTH/SEG_WIDTH.

Ports (clock and reset first):
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- c_in  in  1  carry-in when adding; borrow-in when subtracting.
- sub_in  in  1  0 = add, 1 = subtract.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept an operation this cycle.
- sum_out  out  WIDTH  result.
- carry_out  out  1  carry out of the MSB (raw adder carry).
- overflow_out  out  1  two's-complement signed overflow.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.

## Operation
- The effective operation is A + B' + cin'.
  - Add: B' = b_in, cin' = c_in.
  - Subtract: B' = ~b_in, cin' = ~c_in, so the result is a_in − b_in − c_in.
  - In subtract mode, carry_out = 1 means no borrow.
- Stage k (k = 0..STAGES−1) ripples bits [k·SEG_WIDTH +: SEG_WIDTH] using the carry registered from stage k−1; stage 0 uses cin'.
- Upper operand segments are skewed: they travel through input delay registers so each one reaches its stage together with its carry.
- Lower result segments are de-skewed through output delay registers, so all of sum_out appears in the same cycle.
- overflow_out = carry into the MSB XOR carry out of the MSB, both taken from the last stage.
- Each stage holds a valid bit; there is no other state machine.
- Global advance: adv = ~out_valid | out_ready.
  - in_ready = adv.
  - When adv = 1, every stage register and valid bit shifts forward one stage, and stage 0 captures in_valid & in_ready.
  - When adv = 0, all registers hold.
- Operand and sub_in registers load only when the incoming valid is 1. Datapath contents of bubbles are don't-care, but outputs must not change while out_valid = 1 and out_ready = 0.

## Timing
- Latency: STAGES cycles from accept (in_valid & in_ready at an edge) to out_valid = 1, with no stall.
- Throughput: 1 operation per cycle while out_ready = 1.
- in_ready is combinational from out_valid and out_ready; there is no combinational path from a_in, b_in or c_in to any output.
- Once out_valid = 1, sum_out, carry_out and overflow_out stay stable until the cycle in which out_ready = 1.
- Reset (asserted asynchronously at any time, including mid-pipeline):
  - all valid bits clear, so out_valid = 0 and in-flight operations are discarded;
  - sum_out = 0, carry_out = 0, overflow_out = 0;
  - in_ready = 1 in the first cycle after deassertion.
- SEG_WIDTH = WIDTH gives STAGES = 1: a single registered adder with 1-cycle latency and no skew registers.
- Simultaneous accept and output drain in the same cycle is legal and loses no data.
- Wrap-around: the result is modulo 2^WIDTH; carry_out and overflow_out report the excess.

## Structure
- Shared package/include adder_pkg:
  - STAGES derivation function;
  - a WIDTH % SEG_WIDTH == 0 elaboration check;
  - opcode constants OP_ADD = 0, OP_SUB = 1.
- One sub-module, adder_segment: a combinational SEG_WIDTH-bit ripple of bit-level full adders, with inputs a, b, cin and outputs s, cout, and c_msb_in (the carry into its top bit, used for overflow).
  - The top level instantiates STAGES copies and adds the pipeline, skew and handshake registers.

## Test plan
All scenarios use WIDTH = 16, SEG_WIDTH = 4, STAGES = 4.
1. Add 0x00FF + 0x0001, c_in = 0 → 4 cycles later sum_out = 0x0100, carry_out = 0, overflow_out = 0 (carry crosses a segment boundary).
2. Add 0xFFFF + 0x0000, c_in = 1 → sum_out = 0x0000, carry_out = 1, overflow_out = 0. Then add 0x7FFF + 0x0001 → sum_out = 0x8000, overflow_out = 1.
3. Subtract 0x0005 − 0x0007, c_in = 0 → sum_out = 0xFFFE, carry_out = 0 (borrow). Subtract 0x8000 − 0x0001 → sum_out = 0x7FFF, overflow_out = 1.
4. Back-to-back: 8 operations on consecutive cycles with out_ready = 1 → 8 results on consecutive cycles, in order, first at cycle 4.
5. Backpressure: stream 6 operations and hold out_ready = 0 for 5 cycles mid-stream.
   - in_ready = 0 while out_valid = 1 and out_ready = 0.
   - Outputs stay stable throughout the stall.
   - No operation is lost or duplicated.
6. Assert rst_n = 0 with 3 operations in flight → out_valid = 0 and all outputs 0 immediately. After release, in_ready = 1 and a new operation 0x1234 + 0x1111 returns 0x2345.

Source files
------------

// File: rtl/pipelined_ripple_adder_pkg.sv
// Shared definitions for the pipelined ripple adder.
//   calc_stages  : number of ripple segments (= pipeline stages) for a width.
//   seg_width_ok : true when the operand width splits evenly into segments.
//   full_add     : one-bit full adder, returns {carry, sum}.
//   OP_ADD/OP_SUB: encoding of the sub_in opcode bit.
package pipelined_ripple_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int calc_stages(input int width, input int seg_width);
    return width / seg_width;
  endfunction

  function automatic bit seg_width_ok(input int width, input int seg_width);
    return (seg_width > 0) && (width >= seg_width) && ((width % seg_width) == 0);
  endfunction

  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/pipelined_ripple_adder_if.sv
// Operand/result bus of the pipelined ripple adder.
//   a_in, b_in, c_in, sub_in, in_valid : operation request (master -> slave)
//   in_ready                           : slave can take an operation this cycle
//   sum_out, carry_out, overflow_out   : result (slave -> master)
//   out_valid                          : result valid
//   out_ready                          : master consumes the result
interface pipelined_ripple_adder_if #(
  parameter int WIDTH = 32
) ();

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             sub_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             overflow_out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a_in, b_in, c_in, sub_in, in_valid, out_ready,
    input  in_ready, sum_out, carry_out, overflow_out, out_valid
  );

  modport slave (
    input  a_in, b_in, c_in, sub_in, in_valid, out_ready,
    output in_ready, sum_out, carry_out, overflow_out, out_valid
  );

endinterface

// File: rtl/pipelined_ripple_adder_segment.sv
// Combinational SEG_WIDTH-bit ripple-carry segment built from bit-level
// full adders.
//   a, b     : segment operands (b already inverted for subtraction)
//   cin      : carry into bit 0
//   s        : segment sum
//   cout     : carry out of the top bit
//   c_msb_in : carry into the top bit (overflow detection in the last segment)
module pipelined_ripple_adder_segment
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int SEG_WIDTH = 8
) (
  input  logic [SEG_WIDTH-1:0] a,
  input  logic [SEG_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [SEG_WIDTH-1:0] s,
  output logic                 cout,
  output logic                 c_msb_in
);

  // The carry is a block-local variable so the ripple is one sequential
  // evaluation rather than a vector whose bits feed each other.
  always_comb begin
    logic       cy;
    logic [1:0] fa;
    s        = '0;
    c_msb_in = 1'b0;
    fa       = 2'b00;
    cy       = cin;
    for (int i = 0; i < SEG_WIDTH; i++) begin
      if (i == SEG_WIDTH - 1) begin
        c_msb_in = cy;
      end
      fa   = full_add(a[i], b[i], cy);
      s[i] = fa[0];
      cy   = fa[1];
    end
    cout = cy;
  end

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor.
// A WIDTH-bit operation is split into STAGES = WIDTH/SEG_WIDTH segments; each
// pipeline level ripples one segment and registers its carry for the next.
// Upper operand segments are delayed (skewed) so they meet their carry, and
// lower sum segments are delayed (de-skewed) so the whole sum leaves together.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : operand/result bus (slave side), valid/ready on both ends
// Handshake: one global advance, adv = ~out_valid | out_ready. Every level
// shifts on adv and holds otherwise; in_ready = adv.
module pipelined_ripple_adder
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pipelined_ripple_adder_if.slave  bus
);

  localparam int STAGES = calc_stages(WIDTH, SEG_WIDTH);

  if (!seg_width_ok(WIDTH, SEG_WIDTH)) begin : g_width_check
    $error("pipelined_ripple_adder: WIDTH must be a non-zero multiple of SEG_WIDTH");
  end

  logic                 adv;
  logic [STAGES-1:0]    vld_q;
  // ld[j]: level j+1 registers capture this cycle (advance with valid data
  // arriving from level j, level 0 being the input port).
  logic [STAGES-1:0]    ld;
  logic [WIDTH-1:0]     b_eff;
  logic                 cin_eff;

  logic [SEG_WIDTH-1:0] seg_a  [STAGES];
  logic [SEG_WIDTH-1:0] seg_b  [STAGES];
  logic [SEG_WIDTH-1:0] seg_s  [STAGES];
  logic                 seg_ci [STAGES];
  logic                 seg_co [STAGES];
  logic                 seg_cm [STAGES];

  logic [STAGES-1:0]    carry_q;
  logic                 ovf_q;
  logic [WIDTH-1:0]     sum_q;

  assign adv          = ~vld_q[STAGES-1] | bus.out_ready;
  assign bus.in_ready = adv;

  // Subtraction is A + ~B + ~borrow; the inversion happens once at the input
  // so the skew registers carry the effective operand.
  assign b_eff   = (bus.sub_in == OP_SUB) ? ~bus.b_in : bus.b_in;
  assign cin_eff = (bus.sub_in == OP_ADD) ? bus.c_in  : ~bus.c_in;

  always_comb begin
    ld    = '0;
    ld[0] = adv & bus.in_valid;
    for (int j = 1; j < STAGES; j++) begin
      ld[j] = adv & vld_q[j-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q[0] <= bus.in_valid;
      for (int j = 1; j < STAGES; j++) begin
        vld_q[j] <= vld_q[j-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    localparam int SUM_DEPTH = STAGES - k;

    if (k == 0) begin : g_first
      assign seg_a[0]  = bus.a_in[SEG_WIDTH-1:0];
      assign seg_b[0]  = b_eff[SEG_WIDTH-1:0];
      assign seg_ci[0] = cin_eff;
    end else begin : g_skew
      // Segment k waits k levels for the carry chain to reach it.
      logic [SEG_WIDTH-1:0] a_dly [k];
      logic [SEG_WIDTH-1:0] b_dly [k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < k; i++) begin
            a_dly[i] <= '0;
            b_dly[i] <= '0;
          end
        end else begin
          if (ld[0]) begin
            a_dly[0] <= bus.a_in[k*SEG_WIDTH +: SEG_WIDTH];
            b_dly[0] <= b_eff[k*SEG_WIDTH +: SEG_WIDTH];
          end
          for (int i = 1; i < k; i++) begin
            if (ld[i]) begin
              a_dly[i] <= a_dly[i-1];
              b_dly[i] <= b_dly[i-1];
            end
          end
        end
      end

      assign seg_a[k]  = a_dly[k-1];
      assign seg_b[k]  = b_dly[k-1];
      assign seg_ci[k] = carry_q[k-1];
    end

    pipelined_ripple_adder_segment #(
      .SEG_WIDTH (SEG_WIDTH)
    ) u_seg (
      .a        (seg_a[k]),
      .b        (seg_b[k]),
      .cin      (seg_ci[k]),
      .s        (seg_s[k]),
      .cout     (seg_co[k]),
      .c_msb_in (seg_cm[k])
    );

    // Sum segment k is produced at level k+1 and rides the remaining levels
    // so that every segment reaches sum_out in the same cycle.
    logic [SEG_WIDTH-1:0] s_dly [SUM_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < SUM_DEPTH; i++) begin
          s_dly[i] <= '0;
        end
      end else begin
        if (ld[k]) begin
          s_dly[0] <= seg_s[k];
        end
        for (int i = 1; i < SUM_DEPTH; i++) begin
          if (ld[k+i]) begin
            s_dly[i] <= s_dly[i-1];
          end
        end
      end
    end

    assign sum_q[k*SEG_WIDTH +: SEG_WIDTH] = s_dly[SUM_DEPTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          carry_q[k] <= seg_co[k];
        end
      end
      if (ld[STAGES-1]) begin
        ovf_q <= seg_co[STAGES-1] ^ seg_cm[STAGES-1];
      end
    end
  end

  assign bus.sum_out      = sum_q;
  assign bus.carry_out    = carry_q[STAGES-1];
  assign bus.overflow_out = ovf_q;
  assign bus.out_valid    = vld_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder at WIDTH=16, SEG_WIDTH=4 (4 stages).
// Directed vectors with hand-computed results are pushed into a scoreboard
// as they are accepted; a monitor pops and compares on every output handshake
// and also watches stall behaviour.
module tb_pipelined_ripple_adder;
  import pipelined_ripple_adder_pkg::*;

  localparam int W  = 16;
  localparam int SW = 4;
  localparam int S  = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pipelined_ripple_adder_if #(.WIDTH(W)) bus ();

  pipelined_ripple_adder #(
    .WIDTH     (W),
    .SEG_WIDTH (SW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
    int           exp_cyc;
    bit           chk_lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic sub, input logic [W-1:0] es, input logic eco,
                      input logic eov, input bit lat);
    exp_t e;
    bit   done = 1'b0;
    bus.a_in     = a;
    bus.b_in     = b;
    bus.c_in     = c;
    bus.sub_in   = sub;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      #1;
      if (bus.in_ready) begin
        e.sum     = es;
        e.co      = eco;
        e.ov      = eov;
        e.exp_cyc = cyc + S;
        e.chk_lat = lat;
        sb_q.push_back(e);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles, required 1");
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.a_in     = '0;
    bus.b_in     = '0;
    bus.c_in     = 1'b0;
    bus.sub_in   = OP_ADD;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && sb_q.size() != 0; n++) @(negedge clk);
    check("drain_queue_empty", sb_q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: samples 3 time units after the falling edge, when both DUT and
  // bench-driven signals are settled for the coming rising edge.
  logic [W-1:0] held_sum;
  logic         held_co, held_ov;
  bit           stalled = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled && bus.out_valid) begin
          check("stall_sum_stable", bus.sum_out, held_sum);
          check("stall_carry_stable", bus.carry_out, held_co);
          check("stall_ovf_stable", bus.overflow_out, held_ov);
        end
        if (bus.out_valid && !bus.out_ready) begin
          check("stall_in_ready_low", bus.in_ready, 1'b0);
          held_sum = bus.sum_out;
          held_co  = bus.carry_out;
          held_ov  = bus.overflow_out;
          stalled  = 1'b1;
        end else begin
          stalled = 1'b0;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: sum %0h with empty scoreboard", bus.sum_out);
          end else begin
            e = sb_q.pop_front();
            check("sum_out", bus.sum_out, e.sum);
            check("carry_out", bus.carry_out, e.co);
            check("overflow_out", bus.overflow_out, e.ov);
            if (e.chk_lat) check("latency_cycle", cyc, e.exp_cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_sum", bus.sum_out, 16'h0000);
    check("reset_carry", bus.carry_out, 1'b0);
    check("reset_ovf", bus.overflow_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);

    // 1: carry across a segment boundary
    send(16'h00FF, 16'h0001, 1'b0, OP_ADD, 16'h0100, 1'b0, 1'b0, 1'b1);
    idle();
    drain();

    // 2: full carry ripple, signed overflow
    send(16'hFFFF, 16'h0000, 1'b1, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b1, 1'b1);
    idle();
    drain();

    // 3: subtraction with borrow, signed overflow
    send(16'h0005, 16'h0007, 1'b0, OP_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, OP_SUB, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    idle();
    drain();

    // 4: back-to-back, results must be consecutive and exactly S cycles out
    send(16'h0001, 16'h0002, 1'b0, OP_ADD, 16'h0003, 1'b0, 1'b0, 1'b1);
    send(16'h1111, 16'h2222, 1'b0, OP_ADD, 16'h3333, 1'b0, 1'b0, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b0, OP_ADD, 16'hFFFE, 1'b1, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b1, 1'b1);
    send(16'h0F0F, 16'h00F1, 1'b0, OP_ADD, 16'h1000, 1'b0, 1'b0, 1'b1);
    send(16'h1000, 16'h0001, 1'b0, OP_SUB, 16'h0FFF, 1'b1, 1'b0, 1'b1);
    send(16'h0000, 16'h0001, 1'b1, OP_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    send(16'h4000, 16'h4000, 1'b1, OP_ADD, 16'h8001, 1'b0, 1'b1, 1'b1);
    idle();
    drain();

    // 5: backpressure for 5 cycles mid-stream
    fork
      begin
        send(16'h0100, 16'h0200, 1'b0, OP_ADD, 16'h0300, 1'b0, 1'b0, 1'b0);
        send(16'h0A0A, 16'h0505, 1'b0, OP_ADD, 16'h0F0F, 1'b0, 1'b0, 1'b0);
        send(16'h0300, 16'h0100, 1'b0, OP_SUB, 16'h0200, 1'b1, 1'b0, 1'b0);
        send(16'hABCD, 16'h1234, 1'b0, OP_ADD, 16'hBE01, 1'b0, 1'b0, 1'b0);
        send(16'h7FFF, 16'hFFFF, 1'b0, OP_SUB, 16'h8000, 1'b0, 1'b1, 1'b0);
        send(16'h2000, 16'h6000, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b1, 1'b0);
        idle();
      end
      begin
        repeat (5) @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (5) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // 6: asynchronous reset with operations in flight
    bus.out_ready = 1'b0;
    send(16'hFFFF, 16'h8000, 1'b0, OP_ADD, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    send(16'h0F00, 16'h0100, 1'b0, OP_ADD, 16'h1000, 1'b0, 1'b0, 1'b0);
    send(16'h00AA, 16'h0055, 1'b0, OP_ADD, 16'h00FF, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_sum", bus.sum_out, 16'h0000);
    check("midrst_carry", bus.carry_out, 1'b0);
    check("midrst_ovf", bus.overflow_out, 1'b0);
    sb_q.delete();
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("midrst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    send(16'h1234, 16'h1111, 1'b0, OP_ADD, 16'h2345, 1'b0, 1'b0, 1'b1);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
